mux_nx1_arb: RTL and testbench
==============================

MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

Interface
REQ-001 Parameter SIZE, default 4, data width per channel in bits (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 0; 0 = fixed select by mux_sel, 1 = round-robin arbitration (mux_sel ignored).
REQ-004 Localparam SELW = max(1, clog2(CHANNELS)), width of select, pointer and channel-tag fields.
REQ-005 One clock; reset is asynchronous and active-high. Ports: clk (input, 1, rising-edge clock), rst (input, 1, asynchronous active-high reset).
REQ-006 mux_sel  input  SELW  channel selected in MODE 0.
REQ-007 mux_i_valid  input  CHANNELS  per-channel data-valid, bit k = channel k.
REQ-008 mux_i_data  input  CHANNELS*SIZE  flattened data, channel k in bits [k*SIZE +: SIZE].
REQ-009 mux_i_ready  output  CHANNELS  per-channel accept strobe, at most one bit high.
REQ-010 mux_o_valid  output  1  output register holds a word.
REQ-011 mux_o_data  output  SIZE  registered output word.
REQ-012 mux_o_chan  output  SELW  index of the channel that supplied mux_o_data.
REQ-013 mux_o_ready  input  1  downstream accepts the word this cycle.

Function
REQ-014 load = !mux_o_valid || mux_o_ready, combinational.
REQ-015 MODE 0: grant = mux_sel when mux_sel < CHANNELS and mux_i_valid[mux_sel]=1; else no grant; out-of-range mux_sel yields no grant.
REQ-016 MODE 1: grant = first channel with mux_i_valid=1 searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wrap-around); no grant when mux_i_valid=0.
REQ-017 mux_i_ready[k] = load && grant==k; all others 0; no bit high without a grant.
REQ-018 A transfer on channel k occurs in a cycle with mux_i_valid[k] && mux_i_ready[k].
REQ-019 On a rising edge with load=1: mux_o_valid <= (grant exists); when grant exists, mux_o_data <= channel data, mux_o_chan <= grant.
REQ-020 On a rising edge with load=0: mux_o_valid, mux_o_data, mux_o_chan hold; changes on mux_sel or any input have no effect on them.
REQ-021 Latency: word accepted at edge N appears on mux_o_data after edge N; throughput one word per cycle when mux_o_ready stays 1.
REQ-022 MODE 1 pointer: on every transfer ptr <= grant+1, wrapping CHANNELS-1 -> 0; unchanged otherwise; MODE 0 leaves ptr at 0.
REQ-023 mux_o_valid=1 and mux_o_ready=1 with a new grant in the same cycle: old word consumed and new word loaded at the same edge (no bubble).
REQ-024 mux_o_data and mux_o_chan when mux_o_valid=0 are don't-care for consumers but are not X after reset.

Reset
REQ-025 While rst=1: mux_o_valid=0, mux_o_data=0, mux_o_chan=0, ptr=0, asynchronously, regardless of clk.
REQ-026 mux_i_ready is 0 for all channels whenever no grant exists; during rst it follows REQ-017 using reset register values but no transfer is recorded.
REQ-027 Reset asserted mid-transfer discards the held word; first edge after rst deasserts behaves as from an empty register.

Structure
REQ-028 Shared package mux_pkg holds MODE encodings (MODE_FIXED=0, MODE_RR=1) and the SELW clog2 helper.
REQ-029 One sub-module, rr_arbiter (CHANNELS, SELW params; inputs req vector and ptr; outputs grant index and grant-valid), purely combinational; top instantiates it only when MODE=1.
REQ-030 Output register and pointer live in the top module; no other state.

Verification (SIZE=4, CHANNELS=4)
REQ-031 MODE 0, sel=2, i_valid=0100, data ch2=0xA, o_ready=1 -> i_ready=0100; next cycle o_valid=1, o_data=0xA, o_chan=2.
REQ-032 MODE 0, sel=1, i_valid=0100 -> i_ready=0000, o_valid=0 next cycle.
REQ-033 MODE 1, i_valid=1111 held, o_ready=1, data chK=K -> o_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 MODE 1, o_valid=1 with o_data=0x5, o_ready=0 for 3 cycles, inputs toggling -> i_ready=0000, o_data stays 0x5; o_ready=1 -> new word loaded next edge.
REQ-035 MODE 1, ptr=3, i_valid=0011 -> grant=0 (wrap), ptr becomes 1.
REQ-036 rst pulsed between clock edges while o_valid=1 -> o_valid=0, o_data=0, o_chan=0 immediately; ptr=0 after release.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 arbitrated mux: mode encodings and select-width helper.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Select/pointer/tag width; never narrower than one bit.
  function automatic int selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [SELW-1:0]     gnt,
  output logic                gnt_vld
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req[idx]) begin
        gnt     = SELW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_arb.sv
// N:1 mux with fixed-select or round-robin grant feeding a one-deep output register.
module mux_nx1_arb
  import mux_pkg::*;
#(
  parameter  int SIZE     = 4,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_FIXED,
  localparam int SELW     = selw(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SELW-1:0]          mux_sel,
  input  logic [CHANNELS-1:0]      mux_i_valid,
  input  logic [CHANNELS*SIZE-1:0] mux_i_data,
  output logic [CHANNELS-1:0]      mux_i_ready,
  output logic                     mux_o_valid,
  output logic [SIZE-1:0]          mux_o_data,
  output logic [SELW-1:0]          mux_o_chan,
  input  logic                     mux_o_ready
);

  logic            load;
  logic            gnt_vld;
  logic [SELW-1:0] gnt;
  logic [SIZE-1:0] gnt_data;

  assign load = !mux_o_valid || mux_o_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] ptr;

      rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_arb (
        .req     (mux_i_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
      );

      // Pointer advances past the winner only when a word is actually taken.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  ptr <= '0;
        else if (load && gnt_vld) ptr <= (int'(gnt) == CHANNELS - 1) ? '0 : gnt + 1'b1;
      end
    end else begin : g_fixed
      // Compare against each real channel so an out-of-range select never grants.
      always_comb begin
        gnt     = mux_sel;
        gnt_vld = 1'b0;
        for (int k = 0; k < CHANNELS; k++)
          if (int'(mux_sel) == k) gnt_vld = mux_i_valid[k];
      end
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (int'(gnt) == k) gnt_data = mux_i_data[k*SIZE +: SIZE];
  end

  always_comb begin
    mux_i_ready = '0;
    for (int k = 0; k < CHANNELS; k++)
      mux_i_ready[k] = load && gnt_vld && (int'(gnt) == k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_o_valid <= 1'b0;
      mux_o_data  <= '0;
      mux_o_chan  <= '0;
    end else if (load) begin
      mux_o_valid <= gnt_vld;
      if (gnt_vld) begin
        mux_o_data <= gnt_data;
        mux_o_chan <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Scoreboard bench: fixed-select and round-robin instances side by side, 4x4-bit channels.
module tb_mux_nx1_arb;

  localparam int SIZE = 4;
  localparam int CH   = 4;
  localparam int SELW = 2;

  logic clk, rst;
  logic [SELW-1:0]    sel0, sel1;
  logic [CH-1:0]      v0, v1, rdy0, rdy1;
  logic [CH*SIZE-1:0] d0, d1;
  logic               ov0, ov1, ordy0, ordy1;
  logic [SIZE-1:0]    od0, od1;
  logic [SELW-1:0]    oc0, oc1;

  int n_vec = 0;
  int n_err = 0;
  logic [SIZE+SELW-1:0] q0[$], q1[$];

  mux_nx1_arb #(.SIZE(SIZE), .CHANNELS(CH), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .mux_sel(sel0), .mux_i_valid(v0), .mux_i_data(d0),
    .mux_i_ready(rdy0), .mux_o_valid(ov0), .mux_o_data(od0), .mux_o_chan(oc0),
    .mux_o_ready(ordy0)
  );

  mux_nx1_arb #(.SIZE(SIZE), .CHANNELS(CH), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .mux_sel(sel1), .mux_i_valid(v1), .mux_i_data(d1),
    .mux_i_ready(rdy1), .mux_o_valid(ov1), .mux_o_data(od1), .mux_o_chan(oc1),
    .mux_o_ready(ordy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: a word is consumed when valid and ready are both high.
  always @(negedge clk) begin
    logic [SIZE+SELW-1:0] e;
    if (!rst && ov0 && ordy0) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL m0_word: got %h/%0d, required no word", od0, oc0);
      end else begin
        e = q0.pop_front();
        if ({od0, oc0} !== e) begin
          n_err++;
          $display("FAIL m0_word: got %h/%0d, required %h/%0d", od0, oc0, e[SELW +: SIZE], e[SELW-1:0]);
        end
      end
    end
    if (!rst && ov1 && ordy1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL m1_word: got %h/%0d, required no word", od1, oc1);
      end else begin
        e = q1.pop_front();
        if ({od1, oc1} !== e) begin
          n_err++;
          $display("FAIL m1_word: got %h/%0d, required %h/%0d", od1, oc1, e[SELW +: SIZE], e[SELW-1:0]);
        end
      end
    end
  end

  task automatic tick(input logic [CH-1:0] r0, input logic [CH-1:0] r1, input string nm);
    @(negedge clk);
    chk({nm, "_rdy0"}, 16'(rdy0), 16'(r0));
    chk({nm, "_rdy1"}, 16'(rdy1), 16'(r1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sel0 = '0; sel1 = '0; v0 = '0; v1 = '0; d0 = '0; d1 = '0;
    ordy0 = 1'b1; ordy1 = 1'b1;
    #3;
    chk("rst_state0", {od0, 2'b0, oc0, 7'b0, ov0}, 16'h0);
    chk("rst_state1", {od1, 2'b0, oc1, 7'b0, ov1}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed select
    sel0 = 2; v0 = 4'b0100; d0 = 16'h0A00; q0.push_back({4'hA, 2'd2});
    tick(4'b0100, 4'b0000, "m0_sel2");
    sel0 = 1; v0 = 4'b0100;
    tick(4'b0000, 4'b0000, "m0_sel1_nogrant");
    chk("m0_nogrant_valid", 16'(ov0), 16'h0);
    sel0 = 3; v0 = 4'b1111; d0 = 16'h3210; q0.push_back({4'h3, 2'd3});
    tick(4'b1000, 4'b0000, "m0_sel3");
    ordy0 = 1'b0; sel0 = 0; v0 = 4'b0001; d0 = 16'h000E;
    tick(4'b0000, 4'b0000, "m0_stall");
    chk("m0_stall_hold", {od0, oc0}, {10'h0, 4'h3, 2'd3});
    ordy0 = 1'b1; q0.push_back({4'hE, 2'd0});
    tick(4'b0001, 4'b0000, "m0_release");
    v0 = '0;
    tick(4'b0000, 4'b0000, "m0_idle");

    // Round robin over all-valid channels
    v1 = 4'b1111; d1 = 16'h3210;
    for (int k = 0; k < 5; k++) begin
      q1.push_back({4'(k % 4), 2'(k % 4)});
      tick(4'b0000, 4'(1 << (k % 4)), "m1_rr");
    end
    v1 = '0;
    tick(4'b0000, 4'b0000, "m1_idle");

    // Backpressure with toggling inputs (ptr = 1 here)
    v1 = 4'b0010; d1 = 16'h0050; q1.push_back({4'h5, 2'd1});
    tick(4'b0000, 4'b0010, "m1_load5");
    ordy1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v1 = (k == 0) ? 4'b1111 : (k == 1) ? 4'b0101 : 4'b1010;
      d1 = 16'($urandom);
      tick(4'b0000, 4'b0000, "m1_stall");
      chk("m1_stall_hold", {od1, oc1}, {10'h0, 4'h5, 2'd1});
    end
    ordy1 = 1'b1; v1 = 4'b1000; d1 = 16'h9000; q1.push_back({4'h9, 2'd3});
    tick(4'b0000, 4'b1000, "m1_resume");

    // Wrap-around from ptr = 3
    v1 = 4'b0100; d1 = 16'h0700; q1.push_back({4'h7, 2'd2});
    tick(4'b0000, 4'b0100, "m1_ptr_to3");
    v1 = 4'b0011; d1 = 16'h00DC; q1.push_back({4'hC, 2'd0});
    tick(4'b0000, 4'b0001, "m1_wrap");
    q1.push_back({4'hD, 2'd1});
    tick(4'b0000, 4'b0010, "m1_ptr1");

    // Async reset while a word is held
    v1 = 4'b0100; d1 = 16'h0600; q1.push_back({4'h6, 2'd2});
    tick(4'b0000, 4'b0100, "m1_load6");
    ordy1 = 1'b0; v1 = '0;
    @(negedge clk);
    chk("m1_held_valid", 16'(ov1), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("m1_async_rst", {od1, 2'b0, oc1, 7'b0, ov1}, 16'h0);
    q1.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    ordy1 = 1'b1; v1 = 4'b1111; d1 = 16'h3210; q1.push_back({4'h0, 2'd0});
    tick(4'b0000, 4'b0001, "m1_after_rst");
    v1 = '0;
    tick(4'b0000, 4'b0000, "drain");
    tick(4'b0000, 4'b0000, "drain");
    chk("q0_empty", 16'(q0.size()), 16'h0);
    chk("q1_empty", 16'(q1.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
